// File: rtl/fixed_round_arbiter_pkg.sv
// Shared FSM state type and round-robin search for the fixed_round_arbiter slice.
package fixed_round_arbiter_pkg;

    localparam int unsigned MAX_REQ   = 32;
    localparam int unsigned MAX_IDX_W = $clog2(MAX_REQ);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arbState_e;

    // First asserted requester at or above ptr, wrapping at numReq; returns ptr when none is valid.
    function automatic int unsigned rrPick(
        input logic [MAX_REQ-1:0] valid,
        input int unsigned        ptr,
        input int unsigned        numReq
    );
        int unsigned idx;
        logic        found;
        rrPick = ptr;
        found  = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = ptr + i;
            if (idx >= numReq) begin
                idx = idx - numReq;
            end
            if (!found && (i < numReq) && valid[idx[MAX_IDX_W-1:0]]) begin
                rrPick = idx;
                found  = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/fixed_round.sv
// Fixed-point requantiser: round half up on dropped fraction bits, then saturate
// to the signed output range.
module fixed_round #(
    parameter int IN_WIDTH       = 8,
    parameter int IN_FRAC_WIDTH  = 4,
    parameter int OUT_WIDTH      = 4,
    parameter int OUT_FRAC_WIDTH = 2
) (
    input  logic [IN_WIDTH-1:0]  data_i,
    output logic [OUT_WIDTH-1:0] data_o
);

    localparam int UP_SHIFT = (OUT_FRAC_WIDTH >= IN_FRAC_WIDTH) ? OUT_FRAC_WIDTH - IN_FRAC_WIDTH : 0;
    localparam int DN_SHIFT = (OUT_FRAC_WIDTH <  IN_FRAC_WIDTH) ? IN_FRAC_WIDTH - OUT_FRAC_WIDTH : 0;
    localparam int HALF_POS = (DN_SHIFT > 0) ? DN_SHIFT - 1 : 0;
    // One spare bit so the rounding increment can never wrap the top of the input range.
    localparam int GROW_W   = IN_WIDTH + UP_SHIFT + 1;
    localparam int EXT_W    = (GROW_W > OUT_WIDTH + 1) ? GROW_W : OUT_WIDTH + 1;

    localparam logic signed [EXT_W-1:0] ROUND_HALF =
        (DN_SHIFT > 0) ? EXT_W'(64'sd1 <<< HALF_POS) : '0;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [EXT_W-1:0] extended;
    logic signed [EXT_W-1:0] scaled;

    assign extended = {{(EXT_W - IN_WIDTH){data_i[IN_WIDTH-1]}}, data_i};

    if (DN_SHIFT > 0) begin : gRoundDown
        assign scaled = (extended + ROUND_HALF) >>> DN_SHIFT;
    end else begin : gShiftUp
        assign scaled = extended <<< UP_SHIFT;
    end

    always_comb begin
        if (scaled > SAT_MAX) begin
            data_o = SAT_MAX[OUT_WIDTH-1:0];
        end else if (scaled < SAT_MIN) begin
            data_o = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            data_o = scaled[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fixed_round_arbiter.sv
// Round-robin burst arbiter: locks onto one requester until its last beat, requantises
// each beat through fixed_round and presents it from a single ready/valid output register.
module fixed_round_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IN_WIDTH       = 8,
    parameter int IN_FRAC_WIDTH  = 4,
    parameter int OUT_WIDTH      = 4,
    parameter int OUT_FRAC_WIDTH = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0][IN_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0]                 req_last,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [OUT_WIDTH-1:0]               out_data,
    output logic [$clog2(NUM_REQ)-1:0]         out_id,
    output logic                               out_last,
    output logic                               out_valid,
    input  logic                               out_ready
);

    import fixed_round_arbiter_pkg::*;

    localparam int IDW = $clog2(NUM_REQ);

    arbState_e            state_q, state_d;
    logic [IDW-1:0]       grant_q, grant_d;
    logic [IDW-1:0]       rrPtr_q, rrPtr_d;
    logic                 outValid_q, outValid_d;
    logic                 outLast_q, outLast_d;
    logic [OUT_WIDTH-1:0] outData_q, outData_d;
    logic [IDW-1:0]       outId_q, outId_d;

    logic                 slotFree;
    logic                 beatAccept;
    logic [OUT_WIDTH-1:0] roundedData;

    // The output register can take a new beat when it is empty or being drained this cycle.
    assign slotFree   = out_ready || !outValid_q;
    assign beatAccept = (state_q == LOCKED) && req_valid[grant_q] && slotFree;

    fixed_round #(
        .IN_WIDTH       (IN_WIDTH),
        .IN_FRAC_WIDTH  (IN_FRAC_WIDTH),
        .OUT_WIDTH      (OUT_WIDTH),
        .OUT_FRAC_WIDTH (OUT_FRAC_WIDTH)
    ) uRound (
        .data_i (req_data[grant_q]),
        .data_o (roundedData)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rrPtr_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rrPtr_q <= rrPtr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rrPtr_d = rrPtr_q;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = IDW'(rrPick(MAX_REQ'(req_valid), 32'(rrPtr_q), 32'(NUM_REQ)));
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (beatAccept && req_last[grant_q]) begin
                    state_d = IDLE;
                    rrPtr_d = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if ((state_q == LOCKED) && slotFree) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outId_d    = outId_q;
        outLast_d  = outLast_q;
        if (beatAccept) begin
            outValid_d = 1'b1;
            outData_d  = roundedData;
            outId_d    = grant_q;
            outLast_d  = req_last[grant_q];
        end else if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outId_q    <= '0;
            outLast_q  <= 1'b0;
        end else begin
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outId_q    <= outId_d;
            outLast_q  <= outLast_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_id    = outId_q;
    assign out_last  = outLast_q;

endmodule

// File: doc/fixed_round_arbiter.md
FIXED_ROUND_ARBITER -- requirements
Module: fixed_round_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requester channels (>=2).
REQ-002 SHALL have parameter IN_WIDTH, default 8, requester sample width (signed two's complement).
REQ-003 SHALL have parameter IN_FRAC_WIDTH, default 4, requester fractional bits.
REQ-004 SHALL have parameter OUT_WIDTH, default 4, output sample width (signed).
REQ-005 SHALL have parameter OUT_FRAC_WIDTH, default 2, output fractional bits.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port req_data  input  NUM_REQ x IN_WIDTH  per-channel sample.
REQ-009 SHALL have port req_valid  input  NUM_REQ  per-channel valid.
REQ-010 SHALL have port req_last  input  NUM_REQ  marks final beat of a channel burst.
REQ-011 SHALL have port req_ready  output  NUM_REQ  per-channel ready.
REQ-012 SHALL have port out_data  output  OUT_WIDTH  rounded, saturated sample.
REQ-013 SHALL have port out_id  output  $clog2(NUM_REQ)  source channel of out_data.
REQ-014 SHALL have port out_last  output  1  registered copy of req_last for that beat.
REQ-015 SHALL have port out_valid  output  1  output valid.
REQ-016 SHALL have port out_ready  input  1  downstream ready.

Function
REQ-017 SHALL implement FSM with states IDLE and LOCKED; reset state IDLE.
REQ-018 In IDLE, any req_valid asserted SHALL select a grant by round-robin, searching from rr_ptr upward with wrap, and enter LOCKED next cycle; no req_ready in IDLE.
REQ-019 In LOCKED, req_ready[grant] SHALL equal (out_ready OR NOT out_valid); all other req_ready SHALL be 0.
REQ-020 Beat accepted (req_valid[grant] AND req_ready[grant]) in cycle t SHALL appear on out_data/out_id/out_last with out_valid=1 in cycle t+1 (1-cycle latency).
REQ-021 out_valid SHALL clear after an output handshake with no new beat accepted in the same cycle; out_data, out_id, out_last SHALL be held stable while out_valid=1 and out_ready=0.
REQ-022 Accepted beat with req_last=1 SHALL return FSM to IDLE and set rr_ptr=(grant+1) mod NUM_REQ.
REQ-023 Grant SHALL be held through LOCKED even if req_valid[grant] drops mid-burst; other channels wait.
REQ-024 Rounding: round-half-up on dropped fraction bits (add 2^(IN_FRAC_WIDTH-OUT_FRAC_WIDTH-1), arithmetic shift right); if OUT_FRAC_WIDTH>=IN_FRAC_WIDTH, shift left by the difference.
REQ-025 Result SHALL saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], non-symmetric.
REQ-026 A single channel asserting valid continuously SHALL be re-granted after each burst with one IDLE cycle between bursts.
REQ-027 Sustained throughput in LOCKED SHALL be one beat per cycle when out_ready=1.

Reset
REQ-028 rst SHALL asynchronously force state=IDLE, rr_ptr=0, grant=0, out_valid=0, out_data=0, out_id=0, out_last=0, req_ready=0.
REQ-029 rst mid-burst SHALL discard the held output beat and partial burst; after release, arbitration restarts from channel 0.

Structure
REQ-030 FSM state enum and round-robin pick function SHALL reside in shared package fixed_round_arbiter_pkg.
REQ-031 Rounding/saturation SHALL be one instance of the existing fixed_round sub-module on the granted channel's data; arbiter adds only mux, FSM, output register.

Verification
REQ-032 Channel 1 sends 0x13, last=1, out_ready=1 -> next cycle out_data=0x5, out_id=1, out_last=1.
REQ-033 Channel 0 sends 0x7F then 0x80, last on second -> out_data 0x7 then 0x8 (saturation both rails).
REQ-034 Channel 2 sends 0xFA -> out_data=0xF (-0.375 rounds to -0.25).
REQ-035 All 4 channels valid with 2-beat bursts -> grant order 0,1,2,3,0; no beat interleaving across channels.
REQ-036 out_ready held 0 for 3 cycles mid-burst -> out_data stable, req_ready[grant]=0, no beat lost or duplicated.
REQ-037 rst asserted during LOCKED of channel 3 -> outputs zero same cycle; after release, channel 0 granted first when all valid.
